// File: rtl/prio_enc_pkg.sv
// Shared constants, FSM state type and index-width helper for the
// priority interrupt encoder.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Ceiling log2, clamped so a 1-bit index is the narrowest width produced.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first over N bits: starting at 'start', walk either
// ascending (with wrap-around) or descending (with wrap-around) and report
// the first set bit.
module prio_pick #(
  parameter int N      = 8,
  parameter int W      = 3,
  parameter bit ASCEND = 1'b1
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  int           pos;
  logic [W-1:0] pos_w;

  // Scan all N positions in search order; the first hit is latched by 'found'.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    pos_w = '0;
    for (int k = 0; k < N; k++) begin
      if (ASCEND) pos = (int'(start) + k) % N;
      else        pos = (int'(start) + N - k) % N;
      pos_w = W'(pos);
      if (!found && vec[pos_w]) begin
        found = 1'b1;
        index = pos_w;
      end
    end
  end

endmodule

// File: rtl/prio_irq_enc.sv
// Sticky-pending priority interrupt encoder with fixed or round-robin
// arbitration and a valid/ack presentation handshake.
module prio_irq_enc
  import prio_enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] pend
);

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] last_q, last_d;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] start;
  logic         ack_fire;
  logic         pick_found;
  logic [W-1:0] pick_idx;

  assign ack_fire = (state_q == ST_PRESENT) && ack;
  assign elig     = pend_q & ~mask;
  // A request arriving on the same edge as the ack of its own bit wins.
  assign clr      = ack_fire ? (N'(1) << idx_q) : '0;
  assign pend_d   = (pend_q & ~clr) | req;

  // Round-robin resumes one past the last acknowledged index; fixed mode
  // always scans downward from the top bit so the highest index wins.
  always_comb begin
    start = W'(N - 1);
    if (MODE == MODE_RR) begin
      if (last_q == W'(N - 1)) start = '0;
      else                     start = last_q + 1'b1;
    end
  end

  prio_pick #(
    .N      (N),
    .W      (W),
    .ASCEND (MODE == MODE_RR)
  ) u_pick (
    .vec   (elig),
    .start (start),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next-state logic: grant from IDLE, hold while presenting, release on ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          last_d  = idx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and pending registers; reset discards any outstanding grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= W'(N - 1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign valid = (state_q == ST_PRESENT);
  assign idx   = idx_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_prio_irq_enc.sv
// Bench for prio_irq_enc: one fixed-priority and one round-robin instance
// share req/mask/reset, each followed by a behavioural reference model.
module tb_prio_irq_enc;
  import prio_enc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack_f, ack_r;
  logic       valid_f, valid_r;
  logic [2:0] idx_f, idx_r;
  logic [7:0] pend_f, pend_r;

  int n_chk  = 0;
  int n_pass = 0;

  prio_irq_enc #(.N(8), .MODE(MODE_FIXED)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack_f),
    .valid(valid_f), .idx(idx_f), .pend(pend_f)
  );

  prio_irq_enc #(.N(8), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack_r),
    .valid(valid_r), .idx(idx_r), .pend(pend_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference choice: fixed = largest eligible index; round-robin = the
  // eligible index closest after 'last' going upward modulo 8.
  function automatic int ref_pick(input logic [7:0] elig, input int mode, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = 99;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) begin
        if (mode == MODE_FIXED) best = i;
        else begin
          d = (i - last - 1 + 16) % 8;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    return best;
  endfunction

  logic [7:0] m_pend[2], np_d[2];
  logic       m_valid[2], nv_d[2];
  int         m_idx[2], ni_d[2];
  int         m_last[2], nl_d[2];
  logic       ack_v[2];
  int         pk;

  assign ack_v[0] = ack_f;
  assign ack_v[1] = ack_r;

  always_comb begin
    pk = 0;
    for (int i = 0; i < 2; i++) begin
      np_d[i] = m_pend[i] | req;
      nv_d[i] = m_valid[i];
      ni_d[i] = m_idx[i];
      nl_d[i] = m_last[i];
      if (m_valid[i] && ack_v[i]) begin
        np_d[i] = (m_pend[i] & ~(8'd1 << m_idx[i])) | req;
        nl_d[i] = m_idx[i];
        nv_d[i] = 1'b0;
      end else if (!m_valid[i]) begin
        pk = ref_pick(m_pend[i] & ~mask, (i == 0) ? MODE_FIXED : MODE_RR, m_last[i]);
        if (pk >= 0) begin
          nv_d[i] = 1'b1;
          ni_d[i] = pk;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i]  <= '0;
        m_valid[i] <= 1'b0;
        m_idx[i]   <= 0;
        m_last[i]  <= 7;
      end else begin
        m_pend[i]  <= np_d[i];
        m_valid[i] <= nv_d[i];
        m_idx[i]   <= ni_d[i];
        m_last[i]  <= nl_d[i];
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("f_valid", 32'(valid_f), 32'(m_valid[0]));
    check("f_idx",   32'(idx_f),   32'(m_idx[0]));
    check("f_pend",  32'(pend_f),  32'(m_pend[0]));
    check("r_valid", 32'(valid_r), 32'(m_valid[1]));
    check("r_idx",   32'(idx_r),   32'(m_idx[1]));
    check("r_pend",  32'(pend_r),  32'(m_pend[1]));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    ack_f = 1'b0;
    ack_r = 1'b0;
    @(negedge clk);
    check("rst_f_valid", 32'(valid_f), 32'd0);
    check("rst_f_idx",   32'(idx_f),   32'd0);
    check("rst_f_pend",  32'(pend_f),  32'd0);
    check("rst_r_valid", 32'(valid_r), 32'd0);
    check("rst_r_pend",  32'(pend_r),  32'd0);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req(input logic [7:0] r);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_valid(input int inst, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if ((inst == 0) ? valid_f : valid_r) ok = 1'b1;
    end
  endtask

  // Wait for a presentation, check its index, ack it and check the bubble.
  task automatic grant(input int inst, input int exp, input string tag);
    logic ok;
    wait_valid(inst, ok);
    check({tag, "_present"}, 32'(ok), 32'd1);
    check({tag, "_idx"}, 32'((inst == 0) ? idx_f : idx_r), 32'(exp));
    if (inst == 0) ack_f = 1'b1; else ack_r = 1'b1;
    @(negedge clk);
    ack_f = 1'b0;
    ack_r = 1'b0;
    check({tag, "_bubble"}, 32'((inst == 0) ? valid_f : valid_r), 32'd0);
  endtask

  initial begin
    logic       ok;
    logic [7:0] snap;
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    ack_f = 1'b0;
    ack_r = 1'b0;

    // Fixed priority: 7, then 2, then 0, pending drains to zero.
    do_reset();
    pulse_req(8'b1000_0101);
    grant(0, 7, "fix_g7");
    grant(0, 2, "fix_g2");
    grant(0, 0, "fix_g0");
    check("fix_drained", 32'(pend_f), 32'd0);

    // Masked top bit: 3 first, 7 once unmasked.
    do_reset();
    mask = 8'h80;
    pulse_req(8'h88);
    wait_valid(0, ok);
    check("mask_present", 32'(ok), 32'd1);
    check("mask_idx3", 32'(idx_f), 32'd3);
    ack_f = 1'b1;
    mask  = 8'h00;
    @(negedge clk);
    ack_f = 1'b0;
    grant(0, 7, "unmask_g7");

    // Request on the ack edge of the presented bit keeps it pending.
    do_reset();
    pulse_req(8'h20);
    wait_valid(0, ok);
    check("setwin_idx5", 32'(idx_f), 32'd5);
    ack_f = 1'b1;
    req   = 8'h20;
    @(negedge clk);
    ack_f = 1'b0;
    req   = '0;
    check("setwin_pend5", 32'(pend_f[5]), 32'd1);
    grant(0, 5, "setwin_regrant");

    // Hold without ack while inputs toggle; then ack while idle is ignored.
    do_reset();
    pulse_req(8'h08);
    wait_valid(0, ok);
    for (int c = 0; c < 10; c++) begin
      check("hold_idx",   32'(idx_f),   32'd3);
      check("hold_valid", 32'(valid_f), 32'd1);
      req  = 8'($urandom) & 8'h77;
      mask = 8'($urandom);
      @(negedge clk);
    end
    req   = '0;
    mask  = 8'hFF;
    ack_f = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(valid_f), 32'd0);
    snap  = m_pend[0];
    @(negedge clk);
    ack_f = 1'b0;
    check("idle_ack_pend",  32'(pend_f),  32'(snap));
    check("idle_ack_valid", 32'(valid_f), 32'd0);

    // Round-robin with all requests held: 0..7 then wrap to 0.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) grant(1, g % 8, "rr_seq");
    check("fix_hold_under_rr", 32'(idx_f), 32'd7);
    req = '0;

    // Asynchronous reset mid-presentation restarts round-robin from index 0.
    do_reset();
    pulse_req(8'b0101_0100);
    grant(1, 2, "rr_g2");
    wait_valid(1, ok);
    check("rr_pre_rst_idx", 32'(idx_r), 32'd4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_r), 32'd0);
    check("arst_pend",  32'(pend_r),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_req(8'h42);
    grant(1, 1, "rr_post_rst_g1");
    grant(1, 6, "rr_post_rst_g6");

    // Random traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ack_f = 1'($urandom_range(0, 1));
      ack_r = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    req   = '0;
    mask  = '0;
    ack_f = 1'b0;
    ack_r = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/prio_irq_enc.md
PRIO_IRQ_ENC -- requirements
Module: prio_irq_enc

Interface
REQ-001 Parameter N, default 8: number of request inputs, legal range 2..32.
REQ-002 Parameter MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 Derived constant W = clog2(N): index width, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req  input  N  request pulses or levels, sampled each rising edge.
REQ-007 mask  input  N  1 = the corresponding pending bit is not eligible for selection.
REQ-008 ack  input  1  consumer accepts the presented index.
REQ-009 valid  output  1  idx holds a granted request.
REQ-010 idx  output  W  binary index of the granted request.
REQ-011 pend  output  N  current sticky pending register.

Function
REQ-012 Each edge, pend SHALL take the value pend | req, minus the acknowledged bit (REQ-017).
REQ-013 The block SHALL use a two-state FSM, IDLE and PRESENT.
REQ-014 IDLE: if (pend & ~mask) is nonzero, the block SHALL register the selected index into idx, set valid=1, and go to PRESENT; otherwise it SHALL stay in IDLE with valid=0.
REQ-015 Fixed mode SHALL select the highest set index of (pend & ~mask).
REQ-016 Round-robin mode SHALL search ascending from (last+1) mod N with wrap-around and select the first eligible index; last is the most recently acknowledged index.
REQ-017 PRESENT with ack=1: pend[idx] SHALL clear, last SHALL become idx, valid SHALL drop to 0 on the same edge, and the FSM SHALL return to IDLE.
REQ-018 While in PRESENT without ack, idx and valid SHALL hold stable, regardless of changes to req, mask or pend.
REQ-019 ack while valid=0 SHALL be ignored.
REQ-020 If req[idx]=1 on the same edge as the ack of idx, set SHALL win: pend[idx] stays 1.
REQ-021 Latency: a req sampled at edge t SHALL set pend at t; when the FSM is IDLE at t, valid SHALL rise at edge t+1.
REQ-022 Throughput SHALL be at most one grant per two cycles, because of the mandatory IDLE bubble after each ack.
REQ-023 Masked pending bits SHALL stay in pend and become eligible as soon as they are unmasked.
REQ-024 In fixed mode, last SHALL be maintained but have no effect on selection.

Reset
REQ-025 While rst_n=0, and asynchronously on its assertion, the block SHALL force: pend=0, valid=0, idx=0, FSM=IDLE, last=N-1.
REQ-026 Reset asserted during PRESENT SHALL discard the grant without an ack; after release, the first selection SHALL start from the reset state.
REQ-027 Reset deassertion SHALL be used directly (no internal synchroniser); req is ignored while rst_n=0.

Structure
REQ-028 Package prio_enc_pkg SHALL hold the MODE_FIXED and MODE_RR constants, the FSM state enum, and a clog2 function.
REQ-029 Sub-module prio_pick SHALL be a combinational find-first over N bits with a start-pointer input and a direction parameter; it returns found and index.
REQ-030 One prio_pick instance SHALL serve both modes; the rest of the block SHALL be sequential logic in prio_irq_enc.

Verification
REQ-031 N=8, MODE=0: req=8'b1000_0101 for one cycle -> grants 7, 2, 0 in that order, each acked, with valid low one cycle between grants; pend ends at 0.
REQ-032 N=8, MODE=0: mask=8'h80 with pending bits 7 and 3 -> grant 3; unmask -> next grant 7.
REQ-033 N=8, MODE=1: req held at 8'hFF, ack every presentation -> grant sequence 0,1,...,7,0 (wrap-around).
REQ-034 PRESENT idx=5, req[5] pulsed on the ack edge -> pend[5] stays 1 and 5 is granted again next.
REQ-035 Hold ack=0 for 10 cycles while req/mask toggle -> idx and valid unchanged; an ack with valid=0 leaves pend unchanged.
REQ-036 rst_n pulsed low mid-PRESENT (asynchronously, between edges) -> valid=0 and pend=0 immediately; in MODE=1 the first grant after release is the lowest pending index.
